code_fetch_responder: RTL and testbench

CODE_FETCH_RESPONDER -- requirements
Module: code_fetch_responder

---
 rtl/code_fetch_responder_if.sv | 34 +++
 rtl/code_fetch_responder.sv | 179 +++++++++++++++++
 tb/tb_code_fetch_responder.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_fetch_responder_if.sv
// Bus bundle for the code fetch responder: prefetcher request/return side
// and memory read side. The slave modport is the responder itself; the
// master modport is everything around it (prefetcher plus memory).
interface code_fetch_responder_if;
    // Prefetcher request side
    logic        ACT;
    logic [36:0] OFFSET;
    logic [2:0]  TAGo;
    logic        NEXT;
    logic [36:0] LIMIT;
    logic        FLUSH;
    // Data return to the prefetcher
    logic        DRDY;
    logic [8:0]  TAGi;
    logic [63:0] DTi;
    // Memory read request
    logic        MACT;
    logic [33:0] MADDR;
    logic        MNEXT;
    // Memory read data (in order)
    logic        MDRDY;
    logic [63:0] MDAT;
    logic        MERR;

    modport master (
        output ACT, OFFSET, TAGo, LIMIT, FLUSH, MNEXT, MDRDY, MDAT, MERR,
        input  NEXT, DRDY, TAGi, DTi, MACT, MADDR
    );

    modport slave (
        input  ACT, OFFSET, TAGo, LIMIT, FLUSH, MNEXT, MDRDY, MDAT, MERR,
        output NEXT, DRDY, TAGi, DTi, MACT, MADDR
    );
endinterface

// File: rtl/code_fetch_responder.sv
// Code fetch responder: queues line fetch requests from the prefetcher,
// checks them against the code segment limit, issues in-order memory reads
// and returns data (or a limit-fault line) to the prefetcher in request order.
// FLUSH empties the request queue and discards responses still in flight.
module code_fetch_responder #(
    parameter int QDEPTH = 8,
    parameter int MAXOUT = 4
) (
    input logic                   CLK,
    input logic                   RESET,
    code_fetch_responder_if.slave bus
);
    localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int OW = $clog2(MAXOUT + 1);
    localparam int FW = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;

    localparam logic [CW-1:0] Q_FULL = CW'(QDEPTH);
    localparam logic [QW-1:0] Q_LAST = QW'(QDEPTH - 1);
    localparam logic [OW-1:0] O_MAX  = OW'(MAXOUT);
    localparam logic [FW-1:0] F_LAST = FW'(MAXOUT - 1);

    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
        return (p == Q_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [FW-1:0] f_inc(input logic [FW-1:0] p);
        return (p == F_LAST) ? '0 : p + 1'b1;
    endfunction

    // Request queue: line address, last-of-page flag, limit fault flag
    logic [33:0]   q_addr [QDEPTH];
    logic          q_last [QDEPTH];
    logic          q_err  [QDEPTH];
    logic [QW-1:0] q_wr;
    logic [QW-1:0] q_rd;
    logic [CW-1:0] q_cnt;

    // In-flight FIFO holds the last-of-page flag of each issued read
    logic          f_last [MAXOUT];
    logic [FW-1:0] f_wr;
    logic [FW-1:0] f_rd;

    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;

    // Registered return stage
    logic          drdy_p1;
    logic [8:0]    tag_p1;
    logic [63:0]   dat_p1;

    logic q_empty;
    logic head_err;
    logic head_last;
    logic err_in;
    logic push;
    logic issue;
    logic local_pop;
    logic pop;
    logic mem_rsp;
    logic deliver;
    logic unused_tago;

    assign unused_tago = ^bus.TAGo[1:0];

    assign q_empty   = (q_cnt == '0);
    assign head_err  = q_err[q_rd];
    assign head_last = q_last[q_rd];
    assign err_in    = (bus.OFFSET >= bus.LIMIT);

    assign bus.NEXT  = RESET & bus.ACT & ~bus.FLUSH & (q_cnt < Q_FULL);
    assign push      = bus.ACT & bus.NEXT;

    assign bus.MACT  = RESET & ~q_empty & ~head_err & (outstanding < O_MAX) & ~bus.FLUSH;
    assign bus.MADDR = q_addr[q_rd];
    assign issue     = bus.MACT & bus.MNEXT;

    // A faulting head may only retire once every earlier read has returned,
    // otherwise its fault line would overtake real data.
    assign local_pop = RESET & ~q_empty & head_err & (outstanding == '0) & ~bus.MDRDY & ~bus.FLUSH;
    assign pop       = issue | local_pop;

    // MDRDY with nothing outstanding is a protocol error and is ignored
    assign mem_rsp   = bus.MDRDY & (outstanding != '0);
    assign deliver   = mem_rsp & (drop_cnt == '0);

    assign bus.DRDY  = drdy_p1;
    assign bus.TAGi  = tag_p1;
    assign bus.DTi   = dat_p1;

    // Request queue storage and pointers; FLUSH empties it at the edge
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_addr[i] <= '0;
                q_last[i] <= 1'b0;
                q_err[i]  <= 1'b0;
            end
        end else if (bus.FLUSH) begin
            q_rd  <= q_wr;
            q_cnt <= '0;
        end else begin
            if (push) begin
                q_addr[q_wr] <= bus.OFFSET[36:3];
                q_last[q_wr] <= bus.TAGo[2];
                q_err[q_wr]  <= err_in;
                q_wr         <= q_inc(q_wr);
            end
            if (pop) begin
                q_rd <= q_inc(q_rd);
            end
            if (push && !pop) begin
                q_cnt <= q_cnt + 1'b1;
            end else if (pop && !push) begin
                q_cnt <= q_cnt - 1'b1;
            end
        end
    end

    // In-flight FIFO: pushed on issue, popped on every accepted memory response
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            f_wr <= '0;
            f_rd <= '0;
            for (int i = 0; i < MAXOUT; i++) begin
                f_last[i] <= 1'b0;
            end
        end else begin
            if (issue) begin
                f_last[f_wr] <= head_last;
                f_wr         <= f_inc(f_wr);
            end
            if (mem_rsp) begin
                f_rd <= f_inc(f_rd);
            end
        end
    end

    // Outstanding-read counter and the count of responses still to discard
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (issue && !mem_rsp) begin
                outstanding <= outstanding + 1'b1;
            end else if (mem_rsp && !issue) begin
                outstanding <= outstanding - 1'b1;
            end
            if (bus.FLUSH) begin
                drop_cnt <= mem_rsp ? (outstanding - 1'b1) : outstanding;
            end else if (mem_rsp && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // Return stage: one-cycle DRDY pulse per line, tag/data held otherwise
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            drdy_p1 <= 1'b0;
            tag_p1  <= '0;
            dat_p1  <= '0;
        end else if (deliver) begin
            drdy_p1 <= 1'b1;
            tag_p1  <= {4'hA, bus.MERR, 1'b0, f_last[f_rd], 2'b00};
            dat_p1  <= bus.MDAT;
        end else if (local_pop) begin
            drdy_p1 <= 1'b1;
            tag_p1  <= {4'hA, 1'b1, 1'b0, head_last, 2'b00};
            dat_p1  <= '0;
        end else begin
            drdy_p1 <= 1'b0;
        end
    end
endmodule

// File: tb/tb_code_fetch_responder.sv
// Directed bench for code_fetch_responder: a small in-order memory model and
// a return monitor run alongside scenario tasks that compare against
// hand-computed expectations.
module tb_code_fetch_responder;
    logic CLK;
    logic RESET;

    code_fetch_responder_if bus();

    code_fetch_responder #(.QDEPTH(8), .MAXOUT(4)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks;
    int fails;
    int cyc;
    int lat;
    int rsp_cnt;
    int merr_at;
    bit dat_mode;

    logic [33:0] iss_q[$];
    logic [33:0] pend_addr[$];
    int          pend_due[$];
    logic [8:0]  rx_tag[$];
    logic [63:0] rx_dat[$];

    function automatic logic [63:0] mk_data(input logic [33:0] a);
        return {16'hD00D, 14'h0, a};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Memory: records issued reads, returns them in order after lat cycles
    task automatic mem_model();
        logic [33:0] a;
        bus.MDRDY = 1'b0;
        bus.MDAT  = '0;
        bus.MERR  = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus.MACT === 1'b1 && bus.MNEXT === 1'b1) begin
                iss_q.push_back(bus.MADDR);
                pend_addr.push_back(bus.MADDR);
                pend_due.push_back(cyc + lat);
            end
            @(posedge CLK);
            #1;
            cyc++;
            if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
                a = pend_addr.pop_front();
                void'(pend_due.pop_front());
                bus.MDRDY = 1'b1;
                bus.MDAT  = dat_mode ? 64'hA5A5 : mk_data(a);
                bus.MERR  = (rsp_cnt == merr_at);
                rsp_cnt++;
            end else begin
                bus.MDRDY = 1'b0;
                bus.MERR  = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge CLK);
            if (bus.DRDY === 1'b1) begin
                rx_tag.push_back(bus.TAGi);
                rx_dat.push_back(bus.DTi);
            end
        end
    endtask

    task automatic watchdog();
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    endtask

    task automatic clear_logs();
        iss_q.delete();
        rx_tag.delete();
        rx_dat.delete();
        rsp_cnt = 0;
        merr_at = -1;
    endtask

    task automatic send(input logic [36:0] off, input logic [2:0] tag);
        bit ok;
        ok = 1'b0;
        bus.ACT    = 1'b1;
        bus.OFFSET = off;
        bus.TAGo   = tag;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            ok = bus.NEXT;
            tick();
        end
        bus.ACT = 1'b0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL send_accept offset=%h: NEXT=0 throughout, required 1", off);
        end
    endtask

    task automatic wait_rx(input int n, input string name);
        int b;
        b = 0;
        while (rx_tag.size() < n && b < 500) begin
            tick();
            b++;
        end
        repeat (8) tick();
        checks++;
        if (rx_tag.size() != n) begin
            fails++;
            $display("FAIL %s_count: got %0d DRDY pulses, required %0d", name, rx_tag.size(), n);
        end
    endtask

    task automatic wait_iss(input int n, input string name);
        int b;
        b = 0;
        while (iss_q.size() < n && b < 100) begin
            tick();
            b++;
        end
        checks++;
        if (iss_q.size() != n) begin
            fails++;
            $display("FAIL %s_issue: got %0d memory reads, required %0d", name, iss_q.size(), n);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        bus.ACT = 1'b1;
        bus.OFFSET = 37'h100;
        bus.LIMIT = 37'h1000;
        bus.MNEXT = 1'b1;
        repeat (2) tick();
        checks++;
        if (bus.NEXT !== 1'b0) begin fails++; $display("FAIL reset_next: got %b, required 0", bus.NEXT); end
        checks++;
        if (bus.MACT !== 1'b0) begin fails++; $display("FAIL reset_mact: got %b, required 0", bus.MACT); end
        checks++;
        if (bus.DRDY !== 1'b0) begin fails++; $display("FAIL reset_drdy: got %b, required 0", bus.DRDY); end
        checks++;
        if (bus.TAGi !== 9'h0) begin fails++; $display("FAIL reset_tagi: got %h, required 000", bus.TAGi); end
        checks++;
        if (bus.DTi !== 64'h0) begin fails++; $display("FAIL reset_dti: got %h, required 0", bus.DTi); end
        bus.ACT = 1'b0;
        RESET = 1'b1;
        tick();
        // Stray MDRDY with nothing outstanding must produce no return
        clear_logs();
        pend_addr.push_back(34'h0);
        pend_due.push_back(cyc);
        repeat (6) tick();
        checks++;
        if (rx_tag.size() != 0) begin fails++; $display("FAIL stray_mdrdy: got %0d DRDY pulses, required 0", rx_tag.size()); end
    endtask

    task automatic test_page_fetch();
        logic [8:0] et;
        clear_logs();
        lat = 3;
        bus.LIMIT = 37'h1000;
        bus.MNEXT = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send(37'h100 + 37'(8 * i), (i == 31) ? 3'b100 : 3'b000);
        end
        wait_rx(32, "page");
        checks++;
        if (iss_q.size() != 32) begin fails++; $display("FAIL page_issue_count: got %0d, required 32", iss_q.size()); end
        for (int i = 0; i < 32; i++) begin
            if (i < iss_q.size()) begin
                checks++;
                if (iss_q[i] !== 34'h20 + 34'(i)) begin
                    fails++; $display("FAIL page_maddr[%0d]: got %h, required %h", i, iss_q[i], 34'h20 + 34'(i));
                end
            end
            if (i < rx_tag.size()) begin
                et = (i == 31) ? 9'h144 : 9'h140;
                checks++;
                if (rx_tag[i] !== et || rx_dat[i] !== mk_data(34'h20 + 34'(i))) begin
                    fails++;
                    $display("FAIL page_rx[%0d]: got tag %h data %h, required tag %h data %h",
                             i, rx_tag[i], rx_dat[i], et, mk_data(34'h20 + 34'(i)));
                end
            end
        end
        checks++;
        if (bus.DRDY !== 1'b0 || bus.TAGi !== 9'h144 || bus.DTi !== mk_data(34'h3F)) begin
            fails++;
            $display("FAIL page_hold: got drdy %b tag %h data %h, required drdy 0 tag 144 data %h",
                     bus.DRDY, bus.TAGi, bus.DTi, mk_data(34'h3F));
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        logic [8:0] et;
        clear_logs();
        lat = 3;
        bus.LIMIT = 37'h1000;
        bus.MNEXT = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(37'h400 + 37'(8 * i), 3'b000);
        end
        seen = 1'b0;
        bus.ACT = 1'b1;
        bus.OFFSET = 37'h440;
        bus.TAGo = 3'b000;
        repeat (20) begin
            #1;
            if (bus.NEXT === 1'b1) seen = 1'b1;
            tick();
        end
        bus.ACT = 1'b0;
        checks++;
        if (seen) begin fails++; $display("FAIL bp_next_full: NEXT went 1 while full, required 0"); end
        checks++;
        if (iss_q.size() != 0) begin fails++; $display("FAIL bp_no_issue: got %0d reads, required 0", iss_q.size()); end
        bus.MNEXT = 1'b1;
        send(37'h440, 3'b000);
        send(37'h448, 3'b000);
        send(37'h450, 3'b100);
        wait_rx(11, "bp");
        checks++;
        if (iss_q.size() != 11) begin fails++; $display("FAIL bp_issue_count: got %0d, required 11", iss_q.size()); end
        for (int i = 0; i < 11; i++) begin
            if (i < rx_tag.size()) begin
                et = (i == 10) ? 9'h144 : 9'h140;
                checks++;
                if (rx_tag[i] !== et || rx_dat[i] !== mk_data(34'h80 + 34'(i))) begin
                    fails++;
                    $display("FAIL bp_rx[%0d]: got tag %h data %h, required tag %h data %h",
                             i, rx_tag[i], rx_dat[i], et, mk_data(34'h80 + 34'(i)));
                end
            end
        end
    endtask

    task automatic test_limit();
        clear_logs();
        lat = 3;
        dat_mode = 1'b1;
        bus.LIMIT = 37'h108;
        send(37'h100, 3'b000);
        send(37'h108, 3'b100);
        wait_rx(2, "limit");
        dat_mode = 1'b0;
        checks++;
        if (iss_q.size() != 1) begin fails++; $display("FAIL limit_issue_count: got %0d, required 1", iss_q.size()); end
        if (iss_q.size() >= 1) begin
            checks++;
            if (iss_q[0] !== 34'h20) begin fails++; $display("FAIL limit_maddr: got %h, required 20", iss_q[0]); end
        end
        if (rx_tag.size() >= 2) begin
            checks++;
            if (rx_tag[0] !== 9'h140 || rx_dat[0] !== 64'hA5A5) begin
                fails++; $display("FAIL limit_rx0: got tag %h data %h, required tag 140 data a5a5", rx_tag[0], rx_dat[0]);
            end
            checks++;
            if (rx_tag[1] !== 9'h154 || rx_dat[1] !== 64'h0) begin
                fails++; $display("FAIL limit_rx1: got tag %h data %h, required tag 154 data 0", rx_tag[1], rx_dat[1]);
            end
        end
        bus.LIMIT = 37'h1000;
    endtask

    task automatic test_flush();
        clear_logs();
        lat = 12;
        bus.LIMIT = 37'h1000;
        send(37'h300, 3'b000);
        send(37'h308, 3'b000);
        send(37'h310, 3'b000);
        wait_iss(3, "flush_pre");
        bus.FLUSH = 1'b1;
        bus.ACT = 1'b1;
        bus.OFFSET = 37'h200;
        bus.TAGo = 3'b000;
        #1;
        checks++;
        if (bus.NEXT !== 1'b0) begin fails++; $display("FAIL flush_next: got %b, required 0", bus.NEXT); end
        checks++;
        if (bus.MACT !== 1'b0) begin fails++; $display("FAIL flush_mact: got %b, required 0", bus.MACT); end
        tick();
        bus.FLUSH = 1'b0;
        lat = 3;
        send(37'h200, 3'b000);
        wait_rx(1, "flush");
        if (rx_tag.size() >= 1) begin
            checks++;
            if (rx_tag[0] !== 9'h140 || rx_dat[0] !== mk_data(34'h40)) begin
                fails++; $display("FAIL flush_rx: got tag %h data %h, required tag 140 data %h", rx_tag[0], rx_dat[0], mk_data(34'h40));
            end
        end
        checks++;
        if (iss_q.size() != 4) begin fails++; $display("FAIL flush_issue_count: got %0d, required 4", iss_q.size()); end
        else begin
            checks++;
            if (iss_q[3] !== 34'h40) begin fails++; $display("FAIL flush_maddr: got %h, required 40", iss_q[3]); end
        end
    endtask

    task automatic test_merr();
        logic [8:0] et;
        clear_logs();
        lat = 3;
        merr_at = 1;
        send(37'h500, 3'b000);
        send(37'h508, 3'b000);
        send(37'h510, 3'b000);
        wait_rx(3, "merr");
        merr_at = -1;
        for (int i = 0; i < 3; i++) begin
            if (i < rx_tag.size()) begin
                et = (i == 1) ? 9'h150 : 9'h140;
                checks++;
                if (rx_tag[i] !== et || rx_dat[i] !== mk_data(34'hA0 + 34'(i))) begin
                    fails++;
                    $display("FAIL merr_rx[%0d]: got tag %h data %h, required tag %h data %h",
                             i, rx_tag[i], rx_dat[i], et, mk_data(34'hA0 + 34'(i)));
                end
            end
        end
    endtask

    task automatic test_midreset();
        clear_logs();
        lat = 12;
        send(37'h600, 3'b000);
        send(37'h608, 3'b000);
        wait_iss(2, "rst_pre");
        bus.ACT = 1'b1;
        bus.OFFSET = 37'h610;
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.DRDY !== 1'b0 || bus.TAGi !== 9'h0 || bus.DTi !== 64'h0) begin
            fails++; $display("FAIL midrst_outputs: got drdy %b tag %h data %h, required all 0", bus.DRDY, bus.TAGi, bus.DTi);
        end
        checks++;
        if (bus.NEXT !== 1'b0 || bus.MACT !== 1'b0) begin
            fails++; $display("FAIL midrst_handshake: got next %b mact %b, required 0 0", bus.NEXT, bus.MACT);
        end
        pend_addr.delete();
        pend_due.delete();
        repeat (3) tick();
        bus.ACT = 1'b0;
        RESET = 1'b1;
        tick();
        pend_addr.push_back(34'hC0);
        pend_due.push_back(cyc);
        repeat (6) tick();
        checks++;
        if (rx_tag.size() != 0) begin fails++; $display("FAIL midrst_late_mdrdy: got %0d DRDY pulses, required 0", rx_tag.size()); end
        lat = 3;
        send(37'h700, 3'b100);
        wait_rx(1, "midrst_resume");
        if (rx_tag.size() >= 1) begin
            checks++;
            if (rx_tag[0] !== 9'h144 || rx_dat[0] !== mk_data(34'hE0)) begin
                fails++; $display("FAIL midrst_resume_rx: got tag %h data %h, required tag 144 data %h", rx_tag[0], rx_dat[0], mk_data(34'hE0));
            end
        end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        cyc = 0;
        lat = 3;
        rsp_cnt = 0;
        merr_at = -1;
        dat_mode = 1'b0;
        RESET = 1'b0;
        bus.ACT = 1'b0;
        bus.OFFSET = '0;
        bus.TAGo = '0;
        bus.LIMIT = '0;
        bus.FLUSH = 1'b0;
        bus.MNEXT = 1'b0;
        fork
            mem_model();
            monitor();
            watchdog();
        join_none
        test_reset();
        test_page_fetch();
        test_backpressure();
        test_limit();
        test_flush();
        test_merr();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
